div_sequencer: RTL and testbench

Multi-cycle divide controller for the MIPS core's HI/LO unit. It accepts DIV/DIVU issue requests, runs a 32-iteration restoring division on operand magnitudes, applies MIPS sign rules, and writes quotient to LO and remainder to HI. It owns the architectural HI/LO registers, services MTHI/MTLO, and stalls MFHI/MFLO reads while a division is in flight. It sits beside the ALU in the execute stage.

---
 rtl/div_sequencer_if.sv | 27 ++
 rtl/div_sequencer.sv | 106 ++++++++++
 tb/tb_div_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Issue, MTHI/MTLO and readback bundle between the execute stage and the
// HI/LO divide unit.
interface div_sequencer_if;
   logic        div_start;
   logic        div_signed;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] wdata;
   logic        rd_req;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;

   modport master (
      output div_start, div_signed, op_a, op_b, mthi_we, mtlo_we, wdata, rd_req,
      input  hi, lo, busy, done, stall
   );

   modport slave (
      input  div_start, div_signed, op_a, op_b, mthi_we, mtlo_we, wdata, rd_req,
      output hi, lo, busy, done, stall
   );
endinterface

// File: rtl/div_sequencer.sv
// 32-iteration restoring divider owning the MIPS HI/LO registers; divides
// magnitudes, then applies the DIV sign rules in a single fix-up cycle.
module div_sequencer (
   input  logic            clk,
   input  logic            reset,
   div_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   typedef struct packed {
      logic        sign_q;
      logic        sign_r;
      logic        dz;
      logic [31:0] raw_a;
   } div_ctx_t;

   state_t      state, state_nx;
   logic [4:0]  count;
   logic [31:0] rem, quo, divisor;
   div_ctx_t    ctx;
   logic [31:0] hi_r, lo_r;
   logic        done_r;

   logic [31:0] mag_a, mag_b;
   logic [63:0] shifted;
   logic [32:0] trial;

   always_comb begin
      mag_a   = (bus.div_signed && bus.op_a[31]) ? ~bus.op_a + 32'd1 : bus.op_a;
      mag_b   = (bus.div_signed && bus.op_b[31]) ? ~bus.op_b + 32'd1 : bus.op_b;
      shifted = {rem, quo} << 1;
      trial   = {1'b0, shifted[63:32]} - {1'b0, divisor};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.div_start) state_nx = ITER;
         ITER:    if (count == 5'd31) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         ctx     <= '0;
         hi_r    <= '0;
         lo_r    <= '0;
         done_r  <= 1'b0;
      end else begin
         done_r <= (state == FIX);
         // MTHI/MTLO land first so a completing division overrides them
         if (bus.mthi_we) hi_r <= bus.wdata;
         if (bus.mtlo_we) lo_r <= bus.wdata;
         case (state)
            IDLE: if (bus.div_start) begin
               rem        <= '0;
               quo        <= mag_a;
               divisor    <= mag_b;
               count      <= '0;
               ctx.sign_q <= bus.div_signed & (bus.op_a[31] ^ bus.op_b[31]);
               ctx.sign_r <= bus.div_signed & bus.op_a[31];
               ctx.dz     <= (bus.op_b == 32'd0);
               ctx.raw_a  <= bus.op_a;
            end
            ITER: begin
               count <= count + 5'd1;
               if (!trial[32]) begin
                  rem <= trial[31:0];
                  quo <= {shifted[31:1], 1'b1};
               end else begin
                  rem <= shifted[63:32];
                  quo <= shifted[31:0];
               end
            end
            FIX: begin
               // divide-by-zero leaves the dividend untouched in HI
               if (ctx.dz) begin
                  lo_r <= 32'hFFFF_FFFF;
                  hi_r <= ctx.raw_a;
               end else begin
                  lo_r <= ctx.sign_q ? ~quo + 32'd1 : quo;
                  hi_r <= ctx.sign_r ? ~rem + 32'd1 : rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.hi    = hi_r;
   assign bus.lo    = lo_r;
   assign bus.busy  = (state != IDLE);
   assign bus.done  = done_r;
   assign bus.stall = bus.rd_req & (state != IDLE);
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: cycle-level arithmetic model of HI/LO, busy and
// done, checked every negedge, plus directed literal cases and random traffic.
module tb_div_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   div_sequencer_if dif();
   div_sequencer dut (.clk(clk), .reset(reset), .bus(dif));

   int checks = 0;
   int errors = 0;

   // model: remaining busy cycles, pending result, architectural HI/LO
   int          m_cnt  = 0;
   logic        m_done = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ma, mb, qm, rm, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      qm = ma / mb;
      rm = ma % mb;
      q  = (s && (a[31] ^ b[31])) ? -qm : qm;
      r  = (s && a[31]) ? -rm : rm;
      return {r, q};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
      end else begin
         m_done <= 1'b0;
         if (dif.mthi_we) m_hi <= dif.wdata;
         if (dif.mtlo_we) m_lo <= dif.wdata;
         if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_hi   <= p_hi;
               m_lo   <= p_lo;
               m_done <= 1'b1;
            end
         end else if (dif.div_start) begin
            {p_hi, p_lo} <= ref_div(dif.div_signed, dif.op_a, dif.op_b);
            m_cnt <= 33;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy",  {31'd0, dif.busy},  {31'd0, m_cnt > 0});
      chk("done",  {31'd0, dif.done},  {31'd0, m_done});
      chk("hi",    dif.hi, m_hi);
      chk("lo",    dif.lo, m_lo);
      chk("stall", {31'd0, dif.stall}, {31'd0, dif.rd_req && (m_cnt > 0)});
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
      dif.div_signed = s;
      dif.op_a       = a;
      dif.op_b       = b;
      dif.div_start  = 1'b1;
      cyc();
      dif.div_start  = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 40 && !dif.done) begin
         cyc();
         lat++;
      end
      chk("done_timeout", {31'd0, dif.done}, 32'd1);
   endtask

   task automatic div_lit(input string name, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi);
      int lat;
      issue(s, a, b);
      wait_done(lat);
      chk({name, "_lo"}, dif.lo, elo);
      chk({name, "_hi"}, dif.hi, ehi);
      chk({name, "_mlo"}, m_lo, elo);
      chk({name, "_lat"}, lat, 33);
   endtask

   initial begin
      int lat;
      dif.div_start = 0; dif.div_signed = 0; dif.op_a = 0; dif.op_b = 0;
      dif.mthi_we = 0; dif.mtlo_we = 0; dif.wdata = 0; dif.rd_req = 0;
      #1 reset = 1'b1;
      dif.rd_req = 1'b1;
      #2;
      chk("rst_stall", {31'd0, dif.stall}, 32'd0);
      cyc(2);
      dif.rd_req = 1'b0;
      #3 reset = 1'b0;
      cyc();
      chk("rst_hi", dif.hi, 32'd0);
      chk("rst_lo", dif.lo, 32'd0);
      chk("rst_busy", {31'd0, dif.busy}, 32'd0);

      div_lit("divu_100_7",  0, 32'd100,        32'd7,          32'd14,         32'd2);
      div_lit("div_m7_2",    1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
      div_lit("div_7_m2",    1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
      div_lit("div_ovf",     1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
      div_lit("divu_max_1",  0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0);
      div_lit("divu_5_0",    0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5);
      div_lit("div_m5_0",    1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB);
      cyc();

      dif.wdata = 32'h1234_5678; dif.mthi_we = 1'b1;
      cyc();
      dif.mthi_we = 1'b0;
      chk("mthi", dif.hi, 32'h1234_5678);

      // hazards: MTLO and rd_req at N+5, ignored second start at N+10
      issue(0, 32'd1000, 32'd3);
      cyc(4);
      dif.rd_req = 1'b1; dif.mtlo_we = 1'b1; dif.wdata = 32'hDEAD_BEEF;
      cyc();
      dif.mtlo_we = 1'b0;
      chk("mtlo_mid", dif.lo, 32'hDEAD_BEEF);
      chk("stall_mid", {31'd0, dif.stall}, 32'd1);
      cyc(4);
      issue(0, 32'd50, 32'd5);
      wait_done(lat);
      chk("hz_lo", dif.lo, 32'd333);
      chk("hz_hi", dif.hi, 32'd1);
      chk("hz_stall_done", {31'd0, dif.stall}, 32'd0);
      dif.rd_req = 1'b0;
      cyc(3);
      chk("hz_no_second", {31'd0, dif.busy}, 32'd0);

      // async abort mid-division
      issue(0, 32'd100, 32'd7);
      cyc(14);
      #5 reset = 1'b1;
      #1;
      chk("abort_busy", {31'd0, dif.busy}, 32'd0);
      chk("abort_done", {31'd0, dif.done}, 32'd0);
      chk("abort_hi", dif.hi, 32'd0);
      chk("abort_lo", dif.lo, 32'd0);
      cyc(2);
      #3 reset = 1'b0;
      cyc();
      div_lit("divu_9_3", 0, 32'd9, 32'd3, 32'd3, 32'd0);

      // random traffic, including starts while busy and writes on any edge
      for (int i = 0; i < 3000; i++) begin
         dif.div_start  = ($urandom_range(0, 5) == 0);
         dif.div_signed = $urandom_range(0, 1);
         case ($urandom_range(0, 5))
            0:       dif.op_a = 32'h8000_0000;
            1:       dif.op_a = 32'hFFFF_FFFF;
            2:       dif.op_a = $urandom_range(0, 100);
            default: dif.op_a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0:       dif.op_b = 32'd0;
            1:       dif.op_b = 32'hFFFF_FFFF;
            2:       dif.op_b = $urandom_range(1, 20);
            3:       dif.op_b = 32'h8000_0000 | $urandom_range(0, 9);
            default: dif.op_b = $urandom;
         endcase
         dif.mthi_we = ($urandom_range(0, 15) == 0);
         dif.mtlo_we = ($urandom_range(0, 15) == 0);
         dif.wdata   = $urandom;
         dif.rd_req  = $urandom_range(0, 1);
         cyc();
      end
      dif.div_start = 0; dif.mthi_we = 0; dif.mtlo_we = 0; dif.rd_req = 0;
      cyc(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
